spart_rx: RTL

- Serial receiver half of the SPART; reassembles 8N1 frames arriving on rxd into bytes for the bus interface.
- Uses the same divisor_buffer as the SPART transmitter. One bit period is P = divisor_buffer + 1 clocks, counted down from divisor_buffer to 0.
- Sits beside the transmitter under the SPART top. Its outputs feed the receive-buffer/status read path.

---
 rtl/spart_pkg.sv | 19 +
 rtl/spart_baud_cnt.sv | 33 +++
 rtl/spart_rx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
// Types and constants shared by the SPART transmitter and receiver.
package spart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int SPART_DATA_BITS  = 8;
  localparam int SPART_FRAME_BITS = 10;

  // Load value that puts the first sample in the middle of the start bit.
  function automatic logic [15:0] half_period(input logic [15:0] divisor);
    return divisor >> 1;
  endfunction

endpackage

// File: rtl/spart_baud_cnt.sv
// Loadable 16-bit baud down-counter with zero flag; shared by SPART TX and RX.
module spart_baud_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] load_val,
  output logic        zero
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // The owner reloads the counter before every use, so the reset value is never observed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: reassembles 8N1 frames from rxd into bytes for the bus side.
// Define SPART_RX_FRAMING_CHECK_EN to drop frames with a bad stop bit and flag framing_err.
module spart_rx
  import spart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_BITS   = SPART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic [15:0]          divisor_buffer,
  input  logic                 rx_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 rx_busy,
  output logic                 framing_err
);

  localparam int BIT_CNT_W = $clog2(DATA_BITS + 1);

  rx_state_t              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxd_d_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rda_q, rda_d;
  logic                   busy_q, busy_d;
  logic                   ferr_q, ferr_d;

  logic                   rxd_s;
  logic                   baud_load, baud_en, baud_zero;
  logic [15:0]            baud_val;
  logic                   accept, stop_bad;

  assign rxd_s  = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], rxd};

  spart_baud_cnt u_baud_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (baud_load),
    .en       (baud_en),
    .load_val (baud_val),
    .zero     (baud_zero)
  );

  // NOTE: every _d and strobe gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    rda_d     = rda_q;
    ferr_d    = ferr_q;
    baud_load = 1'b0;
    baud_en   = 1'b0;
    baud_val  = divisor_buffer;
    accept    = 1'b0;
    stop_bad  = 1'b0;

    case (state_q)
      IDLE: begin
        // Keep the counter tracking the divisor; only a falling edge arms the frame.
        baud_load = 1'b1;
        if (rxd_d_q && !rxd_s) begin
          baud_val = half_period(divisor_buffer);
          state_d  = START;
        end
      end
      START: begin
        if (baud_zero) begin
          if (rxd_s) begin
            state_d = IDLE;
          end else begin
            baud_load = 1'b1;
            bit_cnt_d = '0;
            state_d   = DATA;
          end
        end else begin
          baud_en = 1'b1;
        end
      end
      DATA: begin
        if (baud_zero) begin
          shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          baud_load = 1'b1;
          if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
            state_d = STOP;
          end
        end else begin
          baud_en = 1'b1;
        end
      end
      STOP: begin
        if (baud_zero) begin
          state_d = IDLE;
`ifdef SPART_RX_FRAMING_CHECK_EN
          accept   = rxd_s;
          stop_bad = !rxd_s;
`else
          accept   = 1'b1;
`endif
        end else begin
          baud_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rx_read) begin
      rda_d  = 1'b0;
      ferr_d = 1'b0;
    end
    // A completing byte wins over a coincident read; an unread byte is simply overwritten.
    if (accept) begin
      rx_data_d = shift_q;
      rda_d     = 1'b1;
    end
    if (stop_bad) begin
      ferr_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sync_q    <= '1;
      rxd_d_q   <= 1'b1;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      rda_q     <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      rxd_d_q   <= rxd_s;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      rda_q     <= rda_d;
      busy_q    <= busy_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rda         = rda_q;
  assign rx_busy     = busy_q;
  assign framing_err = ferr_q;

endmodule
